decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, width of pc, instruction-derived immediate and jmp_pc.
REQ-002 Parameter NREGS, default 32, architectural register count; RA_W = clog2(NREGS) is the register-address width.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 Ports, one per line (name  direction  width  meaning); the clock and reset use the codebase names and are listed first:
 clk  in  1  single clock; all state changes on its rising edge
 reset  in  1  asynchronous, active-low reset
 id_valid  in  1  fetch offers an instruction
 id_ready  out  1  decode accepts the offered instruction this cycle
 id_instr  in  32  instruction word
 id_pc  in  XLEN  pc of id_instr
 ex_valid  out  1  output register holds a valid decoded instruction
 ex_ready  in  1  EX consumes the output register this cycle
 ex_pc, ex_imm  out  XLEN  pc and sign-extended immediate
 ex_rs1, ex_rs2, ex_rd  out  RA_W  source and destination register indices
 ex_alu_op  out  3  000 ld/st address, 001 branch, 010 R-type, 011 I-type, 100 LUI, 101 AUIPC, 110 JAL, 111 JALR
 ex_alu_src  out  2  00 register, 01 immediate, 10 pc
 ex_func3  out  3  instr[14:12]
 ex_func7  out  1  instr[30]
 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  control bits
 wb_valid  in  1  writeback retires a register write
 wb_rd  in  RA_W  register index being written back
 flush  in  1  EX redirect (taken branch or JALR); kills younger work
 jmp  out  1  one-cycle pulse, JAL redirect
 jmp_pc  out  XLEN  JAL target, valid while jmp=1
 illegal  out  1  one-cycle pulse, unknown opcode accepted
 stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Function
REQ-005 A transfer occurs when id_valid=1 and id_ready=1; the output register loads on that edge, giving a latency of 1 cycle.
REQ-006 id_ready = !hazard && !flush && (!ex_valid || ex_ready).
REQ-007 While ex_valid=1 and ex_ready=0, all ex_* outputs hold stable.
REQ-008 When ex_ready=1 and no transfer occurs in the same cycle, ex_valid clears at the next edge.
REQ-009 Decode covers opcodes R 0110011, I 0010011, LUI 0110111, AUIPC 0010111, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111 and JALR 1100111, using the ex_alu_op codes in REQ-004.
REQ-010 Immediates are sign-extended from instr[31] to XLEN using the standard I, S, B, U and J formats; the U format has imm[11:0]=0.
REQ-011 ex_alu_src is 01 for I-type, LOAD, STORE, LUI and JALR; 10 for AUIPC and JAL; 00 otherwise.
REQ-012 ex_reg_write=1 for R, I, LUI, AUIPC, LOAD, JAL and JALR when rd!=0; otherwise 0.
REQ-013 ex_mem_read=1 and ex_mem_to_reg=1 for LOAD only; ex_mem_write=1 for STORE only.
REQ-014 The scoreboard holds NREGS pending bits; bit 0 is always 0.
REQ-015 A scoreboard bit is set on transfer of an instruction with ex_reg_write=1, at index rd.
REQ-016 A scoreboard bit is cleared on wb_valid=1, at index wb_rd.
REQ-017 When set and clear hit the same index in one cycle, set wins.
REQ-018 Source usage: R, BRANCH and STORE use rs1 and rs2; I, LOAD and JALR use rs1; LUI, AUIPC and JAL use no source.
REQ-019 hazard=1 when id_valid=1 and any used source is nonzero, pending, and not equal to wb_rd with wb_valid=1 in the same cycle.
REQ-020 stall_cnt increments by 1 in each cycle with hazard=1, and saturates at all-ones.
REQ-021 A transfer of a JAL pulses jmp for 1 cycle with jmp_pc = id_pc + J-immediate, truncated to XLEN.
REQ-022 The FSM has states RUN and SQUASH; reset enters RUN.
REQ-023 FSM transition RUN->SQUASH occurs on a JAL transfer; SQUASH->RUN occurs on the next transfer or on flush.
REQ-024 In SQUASH, the next transferred instruction is discarded: ex_valid=0, no scoreboard set, and no jmp.
REQ-025 On flush: ex_valid clears at the next edge; when ex_valid=1 and ex_reg_write=1, the scoreboard bit at ex_rd is cleared; id_ready=0 that cycle; wb clears still apply.
REQ-026 An unknown opcode transfers as a bubble: ex_valid=0, illegal=1 for 1 cycle, and scoreboard unchanged.

Reset
REQ-027 While reset=0, asynchronously: ex_valid=0, all ex_* outputs=0, jmp=0, jmp_pc=0, illegal=0, stall_cnt=0, all scoreboard bits=0, FSM=RUN.
REQ-028 The first transfer is permitted on the first rising edge after reset deasserts.

Verification
REQ-029 A bench shall show: ADDI x1 accepted, then ADD x2,x1,x3 offered with no writeback -> id_ready=0 and stall_cnt increments each cycle; wb_valid=1, wb_rd=1 -> ADD accepted in that cycle.
REQ-030 A bench shall show: JAL x1,+8 at pc 0x100 -> jmp=1 and jmp_pc=0x108 for 1 cycle; the following instruction at 0x104 is dropped (ex_valid=0); the instruction at 0x108 decodes normally.
REQ-031 A bench shall show: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* outputs stable and id_ready=0; ex_ready=1 -> next transfer accepted.
REQ-032 A bench shall show: flush=1 while ex holds LW x5 -> ex_valid=0 next cycle and scoreboard bit 5 cleared, so a subsequent ADD using x5 is not stalled.
REQ-033 A bench shall show: opcode 0x7F -> illegal pulse, ex_valid=0, no stall.
REQ-034 A bench shall show: reset=0 asserted mid-stall with scoreboard bits set -> all outputs and scoreboard zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage: turns one RV32 base instruction per transfer into EX control
// and operand fields. It tracks pending register writes in a scoreboard to
// stall RAW hazards, redirects on JAL and squashes the wrong-path instruction
// behind it, and turns unknown opcodes into bubbles with an illegal pulse.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 16,
  localparam int RA_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [31:0]      id_instr,
  input  logic [XLEN-1:0]  id_pc,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic [2:0]       ex_alu_op,
  output logic [1:0]       ex_alu_src,
  output logic [2:0]       ex_func3,
  output logic             ex_func7,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  input  logic             wb_valid,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             flush,
  output logic             jmp,
  output logic [XLEN-1:0]  jmp_pc,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Stall counter sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t state, state_nxt;
  logic   keep;

  logic [6:0]      opcode;
  logic [RA_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic            rd_nonzero;
  logic            dec_legal, dec_rw, dec_reg_write, dec_mr, dec_mw;
  logic            dec_use1, dec_use2, dec_jal;
  logic [2:0]      dec_alu_op;
  logic [1:0]      dec_alu_src;

  logic signed [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
  logic signed [XLEN-1:0] dec_imm, j_off;
  logic [XLEN-1:0]        jal_target;

  logic [NREGS-1:0] pend, sb_set, sb_clr, sb_nxt;
  logic             haz1, haz2, hazard, xfer;

  assign opcode     = id_instr[6:0];
  assign dec_rd     = RA_W'(id_instr[11:7]);
  assign dec_rs1    = RA_W'(id_instr[19:15]);
  assign dec_rs2    = RA_W'(id_instr[24:20]);
  assign rd_nonzero = (id_instr[11:7] != 5'd0);

  assign imm_i = $signed({{20{id_instr[31]}}, id_instr[31:20]});
  assign imm_s = $signed({{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]});
  assign imm_b = $signed({{19{id_instr[31]}}, id_instr[31], id_instr[7],
                          id_instr[30:25], id_instr[11:8], 1'b0});
  assign imm_u = $signed({id_instr[31:12], 12'b0});
  assign imm_j = $signed({{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                          id_instr[20], id_instr[30:21], 1'b0});

  // Opcode decode into control bits, source usage and immediate selection
  always_comb begin
    dec_legal   = 1'b1;
    dec_alu_op  = 3'b000;
    dec_alu_src = 2'b00;
    dec_rw      = 1'b0;
    dec_mr      = 1'b0;
    dec_mw      = 1'b0;
    dec_use1    = 1'b0;
    dec_use2    = 1'b0;
    dec_jal     = 1'b0;
    imm_sel     = '0;
    case (opcode)
      OP_R:      begin dec_alu_op = 3'b010; dec_rw = 1'b1; dec_use1 = 1'b1; dec_use2 = 1'b1; end
      OP_I:      begin dec_alu_op = 3'b011; dec_alu_src = 2'b01; dec_rw = 1'b1; dec_use1 = 1'b1; imm_sel = imm_i; end
      OP_LUI:    begin dec_alu_op = 3'b100; dec_alu_src = 2'b01; dec_rw = 1'b1; imm_sel = imm_u; end
      OP_AUIPC:  begin dec_alu_op = 3'b101; dec_alu_src = 2'b10; dec_rw = 1'b1; imm_sel = imm_u; end
      OP_LOAD:   begin dec_alu_op = 3'b000; dec_alu_src = 2'b01; dec_rw = 1'b1; dec_mr = 1'b1; dec_use1 = 1'b1; imm_sel = imm_i; end
      OP_STORE:  begin dec_alu_op = 3'b000; dec_alu_src = 2'b01; dec_mw = 1'b1; dec_use1 = 1'b1; dec_use2 = 1'b1; imm_sel = imm_s; end
      OP_BRANCH: begin dec_alu_op = 3'b001; dec_use1 = 1'b1; dec_use2 = 1'b1; imm_sel = imm_b; end
      OP_JAL:    begin dec_alu_op = 3'b110; dec_alu_src = 2'b10; dec_rw = 1'b1; dec_jal = 1'b1; imm_sel = imm_j; end
      OP_JALR:   begin dec_alu_op = 3'b111; dec_alu_src = 2'b01; dec_rw = 1'b1; dec_use1 = 1'b1; imm_sel = imm_i; end
      default:   dec_legal = 1'b0;
    endcase
  end

  assign dec_reg_write = dec_rw && rd_nonzero;
  assign dec_imm       = XLEN'(imm_sel);
  assign j_off         = XLEN'(imm_j);
  assign jal_target    = id_pc + j_off;

  // A source is blocked only if pending and not being retired this very cycle
  assign haz1     = dec_use1 && (dec_rs1 != '0) && pend[dec_rs1] && !(wb_valid && wb_rd == dec_rs1);
  assign haz2     = dec_use2 && (dec_rs2 != '0) && pend[dec_rs2] && !(wb_valid && wb_rd == dec_rs2);
  assign hazard   = id_valid && (haz1 || haz2);
  assign id_ready = !hazard && !flush && (!ex_valid || ex_ready);
  assign xfer     = id_valid && id_ready;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // FSM next state: a JAL opens the squash window, next transfer or flush closes it
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (xfer && dec_legal && dec_jal) state_nxt = SQUASH;
      SQUASH:  if (xfer || flush)                state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM outputs: only in RUN does a transfer have any architectural effect
  always_comb begin
    keep = (state == RUN);
  end

  // Scoreboard update: clears from writeback and flushed EX, set has priority
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (xfer && keep && dec_legal && dec_reg_write) sb_set[dec_rd] = 1'b1;
    if (wb_valid)                                   sb_clr[wb_rd]  = 1'b1;
    if (flush && ex_valid && ex_reg_write)          sb_clr[ex_rd]  = 1'b1;
    sb_nxt    = (pend & ~sb_clr) | sb_set;
    sb_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= '0;
    else        pend <= sb_nxt;
  end

  // ---- decode -> EX output register ----
  // Output register: loads on an accepted transfer, drains when EX consumes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_alu_op     <= '0;
      ex_alu_src    <= '0;
      ex_func3      <= '0;
      ex_func7      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (xfer) begin
      ex_valid <= keep && dec_legal;
      if (keep && dec_legal) begin
        ex_pc         <= id_pc;
        ex_imm        <= dec_imm;
        ex_rs1        <= dec_rs1;
        ex_rs2        <= dec_rs2;
        ex_rd         <= dec_rd;
        ex_alu_op     <= dec_alu_op;
        ex_alu_src    <= dec_alu_src;
        ex_func3      <= id_instr[14:12];
        ex_func7      <= id_instr[30];
        ex_reg_write  <= dec_reg_write;
        ex_mem_read   <= dec_mr;
        ex_mem_write  <= dec_mw;
        ex_mem_to_reg <= dec_mr;
      end
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Redirect and illegal pulses, one cycle after the transfer that caused them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jmp     <= 1'b0;
      jmp_pc  <= '0;
      illegal <= 1'b0;
    end else begin
      jmp     <= xfer && keep && dec_legal && dec_jal;
      illegal <= xfer && keep && !dec_legal;
      if (xfer && keep && dec_legal && dec_jal) jmp_pc <= jal_target;
    end
  end

  // Hazard stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      stall_cnt <= '0;
    else if (hazard) stall_cnt <= sat_inc(stall_cnt);
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_decode_stage;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int CNT_W = 4;
  localparam int RA_W  = 5;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_ready;
  logic [31:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic ex_valid, ex_ready;
  logic [XLEN-1:0] ex_pc, ex_imm;
  logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_alu_op;
  logic [1:0] ex_alu_src;
  logic [2:0] ex_func3;
  logic ex_func7, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic wb_valid;
  logic [RA_W-1:0] wb_rd;
  logic flush, jmp, illegal;
  logic [XLEN-1:0] jmp_pc;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_func3(ex_func3), .ex_func7(ex_func7),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .jmp(jmp), .jmp_pc(jmp_pc), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    bit legal;
    int alu_op, alu_src, rd, rs1, rs2, f3, f7, imm;
    bit rw, mr, mw, u1, u2, jal;
  } dec_t;

  // Reference model state
  bit [31:0] m_pend;
  bit        m_squash, m_exv, m_jmp, m_ill, m_rdy;
  dec_t      m_ex;
  int        m_expc, m_jpc, m_stall;

  // Decode by opcode name; immediates rebuilt with plain integer arithmetic
  function automatic dec_t ref_decode(logic [31:0] ins);
    dec_t d;
    int s;
    s = $signed(ins);
    d = '{legal: 1'b1, alu_op: 0, alu_src: 0, rd: int'(ins[11:7]), rs1: int'(ins[19:15]),
          rs2: int'(ins[24:20]), f3: int'(ins[14:12]), f7: int'(ins[30]), imm: 0,
          rw: 1'b0, mr: 1'b0, mw: 1'b0, u1: 1'b0, u2: 1'b0, jal: 1'b0};
    case (ins[6:0])
      7'b0110011: begin d.alu_op = 2; d.rw = 1; d.u1 = 1; d.u2 = 1; end
      7'b0010011: begin d.alu_op = 3; d.alu_src = 1; d.rw = 1; d.u1 = 1; d.imm = s >>> 20; end
      7'b0110111: begin d.alu_op = 4; d.alu_src = 1; d.rw = 1; d.imm = (s >>> 12) * 4096; end
      7'b0010111: begin d.alu_op = 5; d.alu_src = 2; d.rw = 1; d.imm = (s >>> 12) * 4096; end
      7'b0000011: begin d.alu_op = 0; d.alu_src = 1; d.rw = 1; d.mr = 1; d.u1 = 1; d.imm = s >>> 20; end
      7'b0100011: begin d.alu_op = 0; d.alu_src = 1; d.mw = 1; d.u1 = 1; d.u2 = 1;
                        d.imm = (s >>> 25) * 32 + int'(ins[11:7]); end
      7'b1100011: begin d.alu_op = 1; d.u1 = 1; d.u2 = 1;
                        d.imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048
                              + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2; end
      7'b1101111: begin d.alu_op = 6; d.alu_src = 2; d.rw = 1; d.jal = 1;
                        d.imm = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096
                              + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2; end
      7'b1100111: begin d.alu_op = 7; d.alu_src = 1; d.rw = 1; d.u1 = 1; d.imm = s >>> 20; end
      default:    d.legal = 1'b0;
    endcase
    if (d.rd == 0) d.rw = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] enc_i(logic [6:0] op, int rd, int f3, int rs1, int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(int rd, int rs1, int rs2);
    return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_j(int rd, int imm);
    logic [20:0] m;
    m = imm[20:0];
    return {m[20], m[10:1], m[11], m[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_squash = 0; m_exv = 0; m_jmp = 0; m_ill = 0; m_stall = 0;
    m_expc = 0; m_jpc = 0;
    m_ex = ref_decode(32'h0);
  endtask

  task automatic check_outputs();
    chk("ex_valid", 32'(ex_valid), 32'(m_exv));
    if (m_exv) begin
      chk("ex_pc", 32'(ex_pc), 32'(m_expc));
      chk("ex_imm", 32'(ex_imm), 32'(m_ex.imm));
      chk("ex_rs1", 32'(ex_rs1), 32'(m_ex.rs1));
      chk("ex_rs2", 32'(ex_rs2), 32'(m_ex.rs2));
      chk("ex_rd", 32'(ex_rd), 32'(m_ex.rd));
      chk("ex_alu_op", 32'(ex_alu_op), 32'(m_ex.alu_op));
      chk("ex_alu_src", 32'(ex_alu_src), 32'(m_ex.alu_src));
      chk("ex_func3", 32'(ex_func3), 32'(m_ex.f3));
      chk("ex_func7", 32'(ex_func7), 32'(m_ex.f7));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(m_ex.rw));
      chk("ex_mem_read", 32'(ex_mem_read), 32'(m_ex.mr));
      chk("ex_mem_write", 32'(ex_mem_write), 32'(m_ex.mw));
      chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m_ex.mr));
    end
    chk("jmp", 32'(jmp), 32'(m_jmp));
    if (m_jmp) chk("jmp_pc", 32'(jmp_pc), 32'(m_jpc));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic check_reset_zero();
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_ex_pc", 32'(ex_pc), 32'h0);
    chk("rst_ex_imm", 32'(ex_imm), 32'h0);
    chk("rst_ex_regs", 32'({ex_rs1, ex_rs2, ex_rd}), 32'h0);
    chk("rst_ex_ctrl", 32'({ex_alu_op, ex_alu_src, ex_func3, ex_func7, ex_reg_write,
                            ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'h0);
    chk("rst_jmp", 32'(jmp), 32'h0);
    chk("rst_jmp_pc", 32'(jmp_pc), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
  endtask

  // One clock: check id_ready before the edge, advance the model, check after
  task automatic cyc();
    dec_t d;
    bit haz, xfer, keep;
    bit [31:0] np;
    #2;
    d = ref_decode(id_instr);
    haz = id_valid &&
          ((d.u1 && d.rs1 != 0 && m_pend[d.rs1] && !(wb_valid && int'(wb_rd) == d.rs1)) ||
           (d.u2 && d.rs2 != 0 && m_pend[d.rs2] && !(wb_valid && int'(wb_rd) == d.rs2)));
    m_rdy = !haz && !flush && (!m_exv || ex_ready);
    chk("id_ready", 32'(id_ready), 32'(m_rdy));
    xfer = id_valid && m_rdy;
    keep = !m_squash && d.legal;
    np = m_pend;
    if (wb_valid) np[wb_rd] = 1'b0;
    if (flush && m_exv && m_ex.rw) np[m_ex.rd] = 1'b0;
    if (xfer && keep && d.rw) np[d.rd] = 1'b1;
    np[0] = 1'b0;
    if (haz && m_stall < SAT) m_stall++;
    m_jmp = xfer && keep && d.jal;
    if (m_jmp) m_jpc = int'(id_pc) + d.imm;
    m_ill = xfer && !m_squash && !d.legal;
    if (flush) m_exv = 0;
    else if (xfer) begin
      m_exv = keep;
      if (keep) begin m_ex = d; m_expc = int'(id_pc); end
    end else if (ex_ready) m_exv = 0;
    if (!m_squash) m_squash = xfer && d.legal && d.jal;
    else if (xfer || flush) m_squash = 0;
    m_pend = np;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    id_valid = 1'b1; id_instr = ins; id_pc = pc;
  endtask

  task automatic drain();
    id_valid = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      wb_valid = 1'b1; wb_rd = RA_W'(r);
      cyc();
    end
    wb_valid = 1'b0;
  endtask

  logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                           7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'h7F, 7'b0001111};

  initial begin
    int saved;
    reset = 1'b0; id_valid = 1'b0; id_instr = '0; id_pc = '0;
    ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    model_reset();
    #12;
    check_reset_zero();
    @(negedge clk);
    reset = 1'b1;

    // RAW stall on x1, released by a same-cycle writeback
    offer(enc_i(7'b0010011, 1, 0, 0, 5), 32'h0);
    cyc();
    chk("addi_x1_rd", 32'(ex_rd), 32'd1);
    offer(enc_r(2, 1, 3), 32'h4);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("add_stall_ready", 32'(id_ready), 32'h0);
      chk("add_stall_cnt", 32'(stall_cnt), 32'(i));
    end
    wb_valid = 1'b1; wb_rd = 5'd1;
    cyc();
    chk("add_accept_valid", 32'(ex_valid), 32'h1);
    chk("add_accept_rd", 32'(ex_rd), 32'd2);
    wb_valid = 1'b0;

    // JAL redirect and wrong-path squash
    offer(enc_j(1, 8), 32'h100);
    cyc();
    chk("jal_jmp", 32'(jmp), 32'h1);
    chk("jal_target", 32'(jmp_pc), 32'h108);
    offer(enc_i(7'b0010011, 4, 0, 0, 1), 32'h104);
    cyc();
    chk("squash_valid", 32'(ex_valid), 32'h0);
    chk("squash_jmp", 32'(jmp), 32'h0);
    offer(enc_i(7'b0010011, 5, 0, 0, 7), 32'h108);
    cyc();
    chk("after_squash_pc", 32'(ex_pc), 32'h108);
    chk("after_squash_imm", 32'(ex_imm), 32'h7);
    drain();

    // Backpressure holds EX outputs
    ex_ready = 1'b0;
    offer(enc_i(7'b0010011, 6, 0, 0, 12'h823), 32'h200);
    cyc();
    offer(enc_i(7'b0010011, 7, 0, 0, 1), 32'h204);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_pc", 32'(ex_pc), 32'h200);
      chk("hold_imm", 32'(ex_imm), 32'hFFFFF823);
      chk("hold_ready", 32'(id_ready), 32'h0);
    end
    ex_ready = 1'b1;
    cyc();
    chk("release_pc", 32'(ex_pc), 32'h204);
    drain();

    // Flush kills LW x5 and its scoreboard entry
    ex_ready = 1'b0;
    offer(enc_i(7'b0000011, 5, 2, 0, 0), 32'h300);
    cyc();
    chk("lw_mem_read", 32'(ex_mem_read), 32'h1);
    id_valid = 1'b0; flush = 1'b1;
    cyc();
    chk("flush_valid", 32'(ex_valid), 32'h0);
    flush = 1'b0; ex_ready = 1'b1;
    saved = int'(stall_cnt);
    offer(enc_r(8, 5, 0), 32'h304);
    cyc();
    chk("post_flush_add", 32'(ex_valid), 32'h1);
    chk("post_flush_stall", 32'(stall_cnt), 32'(saved));
    drain();

    // Unknown opcode becomes a bubble
    saved = int'(stall_cnt);
    offer(32'h0000007F, 32'h400);
    cyc();
    chk("illegal_pulse", 32'(illegal), 32'h1);
    chk("illegal_valid", 32'(ex_valid), 32'h0);
    chk("illegal_stall", 32'(stall_cnt), 32'(saved));
    id_valid = 1'b0;
    cyc();
    chk("illegal_drop", 32'(illegal), 32'h0);

    // Long stall saturates the counter, then reset lands mid-stall
    offer(enc_i(7'b0010011, 9, 0, 0, 1), 32'h500);
    cyc();
    offer(enc_r(10, 9, 9), 32'h504);
    for (int i = 0; i < 20; i++) cyc();
    chk("stall_saturated", 32'(stall_cnt), 32'(SAT));
    #2;
    reset = 1'b0;
    #1;
    check_reset_zero();
    chk("rst_sb_clear", 32'(id_ready), 32'h1);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc();
    chk("first_after_rst", 32'(ex_valid), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      id_valid = ($urandom_range(0, 9) < 8);
      id_instr = $urandom;
      id_instr[6:0]   = ops[$urandom_range(0, 10)];
      id_instr[11:7]  = 5'($urandom_range(0, 7));
      id_instr[19:15] = 5'($urandom_range(0, 7));
      id_instr[24:20] = 5'($urandom_range(0, 7));
      id_pc = $urandom;
      id_pc[1:0] = 2'b00;
      ex_ready = ($urandom_range(0, 9) < 7);
      wb_valid = ($urandom_range(0, 9) < 3);
      wb_rd    = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
